// File: rtl/mux_scan_sampler_pkg.sv
// Shared types and helpers for the 4:1 mux scan sampler.
// Holds the FSM state encoding and the settle-counter width rule.
package mux_scan_sampler_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } state_e;

  // Counter must hold SETTLE_CYCLES; keep at least one bit when settling is disabled.
  function automatic int unsigned cnt_width(input int unsigned settle);
    return (settle <= 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/mux_scan_sampler_settle_counter.sv
// Settle-time counter: cleared by load, advanced by en, flags the last settle cycle.
// tc is high while the count is on the final cycle of the settle window.
module mux_scan_sampler_settle_counter
  import mux_scan_sampler_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = cnt_width(SETTLE_CYCLES);
  localparam logic [CntW-1:0] TcVal =
    CntW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TcVal);

endmodule

// File: rtl/mux_scan_sampler.sv
// Scans the mux select lines over every channel, samples Y after a settle time
// and publishes the assembled word with a one-cycle valid pulse.
module mux_scan_sampler
  import mux_scan_sampler_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned SEL_W        = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             clear,
  input  logic             y_in,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  data_out,
  output logic             valid,
  output logic             busy
);

  localparam logic [SEL_W-1:0] SelLast = SEL_W'(N_CH - 1);
  // With no settle time each channel goes straight to its sample cycle.
  localparam state_e FirstSt = (SETTLE_CYCLES == 0) ? StSample : StSettle;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_CH-1:0]  shadow_q, shadow_d;
  logic [N_CH-1:0]  data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             cnt_load, cnt_en, cnt_tc;

  mux_scan_sampler_settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;

    if (clear) begin
      state_d  = StIdle;
      sel_d    = '0;
      shadow_d = '0;
      cnt_load = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sel_d    = '0;
            cnt_load = 1'b1;
            state_d  = FirstSt;
          end
        end
        StSettle: begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d = StSample;
          end
        end
        StSample: begin
          shadow_d[sel_q] = y_in;
          if (sel_q == SelLast) begin
            data_d  = {y_in, shadow_q[N_CH-2:0]};
            state_d = StDone;
          end else begin
            sel_d    = sel_q + 1'b1;
            cnt_load = 1'b1;
            state_d  = FirstSt;
          end
        end
        StDone: begin
          sel_d = '0;
          if (cont || start) begin
            cnt_load = 1'b1;
            state_d  = FirstSt;
          end else begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          sel_d   = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    valid_d = (state_d == StDone);
    busy_d  = (state_d == StSettle) || (state_d == StSample);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign sel      = sel_q;
  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule
